// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory responder (dmem_responder, dmem_array).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM, write-first, no reset on contents or read register.
// Latency: read/write data appears on o_rdata one edge after an enabled access.
// Backpressure: none; i_en low holds o_rdata and blocks writes.
module dmem_array #(
  parameter int DATA_W    = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_en,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  output logic [DATA_W-1:0]    o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_BITS];
  logic [DATA_W-1:0] r_rdata;

  // One access per enabled edge; a write returns its own data, a read returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
        r_rdata       <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: every IDLE edge is an access; completion flagged on M_RD_VALID.
// Latency: M_RD_VALID rises WAIT_STATES edges after the sampling edge (same edge when 0).
// Backpressure: none; inputs ignored while waiting. Optional M_ERR port under DMEM_ERR_EN.
module dmem_responder #(
  parameter int DATA_W      = mips_mem_pkg::DATA_W,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              M_CLK,
  input  logic              Z_R,
  input  logic              M_WE,
  input  logic [31:0]       M_ADDR,
  input  logic [DATA_W-1:0] M_WR_DATA,
  output logic [DATA_W-1:0] M_RD_DATA,
  output logic              M_RD_VALID
`ifdef DMEM_ERR_EN
  ,
  output logic              M_ERR
`endif
);

  import mips_mem_pkg::*;

  localparam logic [WAIT_CNT_W-1:0] LP_CNT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  dmem_state_t           r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                  r_vld, w_vld_nxt;
  logic                  r_zero, w_zero_nxt;
  logic                  w_access;
  logic                  w_addr_bad;
  logic                  w_ram_we;
  logic [DATA_W-1:0]     w_rdata;

`ifdef DMEM_ERR_EN
  logic r_err, w_err_nxt;
  assign w_addr_bad = |M_ADDR[31:ADDR_BITS];
`else
  logic w_unused_upper;
  assign w_unused_upper = ^M_ADDR[31:ADDR_BITS];
  assign w_addr_bad     = 1'b0;
`endif

  assign w_access = (r_state == IDLE);
  assign w_ram_we = w_access & M_WE & ~w_addr_bad;

  dmem_array #(
    .DATA_W    (DATA_W),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .i_clk   (M_CLK),
    .i_en    (w_access),
    .i_we    (w_ram_we),
    .i_addr  (M_ADDR[ADDR_BITS-1:0]),
    .i_wdata (M_WR_DATA),
    .o_rdata (w_rdata)
  );

  // State register.
  always_ff @(posedge M_CLK or negedge Z_R) begin
    if (!Z_R) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state: an access leaves IDLE only when wait states are configured.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (WAIT_STATES != 0) w_state_nxt = WAIT;
      WAIT:    if (r_cnt == '0)      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next counter/valid/data-mask/error values for the current state.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_vld_nxt  = r_vld;
    w_zero_nxt = r_zero;
`ifdef DMEM_ERR_EN
    w_err_nxt  = r_err;
`endif
    if (r_state == IDLE) begin
      w_vld_nxt  = (WAIT_STATES == 0);
      w_cnt_nxt  = LP_CNT_LOAD;
      w_zero_nxt = w_addr_bad;
`ifdef DMEM_ERR_EN
      w_err_nxt  = w_addr_bad;
`endif
    end else if (r_cnt == '0) begin
      w_vld_nxt = 1'b1;
    end else begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  // Control registers; r_zero masks the unreset RAM read register until a good access.
  always_ff @(posedge M_CLK or negedge Z_R) begin
    if (!Z_R) begin
      r_cnt  <= '0;
      r_vld  <= 1'b0;
      r_zero <= 1'b1;
`ifdef DMEM_ERR_EN
      r_err  <= 1'b0;
`endif
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_vld  <= w_vld_nxt;
      r_zero <= w_zero_nxt;
`ifdef DMEM_ERR_EN
      r_err  <= w_err_nxt;
`endif
    end
  end

  assign M_RD_DATA  = r_zero ? '0 : w_rdata;
  assign M_RD_VALID = r_vld;
`ifdef DMEM_ERR_EN
  assign M_ERR      = r_err;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_STATES 0, 2, 3) share one input stream.
// A per-instance behavioural model is compared every negedge; directed checks pin key values.
// Build with or without DMEM_ERR_EN; expectations follow the build.
module tb_dmem_responder;

`ifdef DMEM_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;

  logic [31:0] rd0, rd2, rd3;
  logic        vld0, vld2, vld3;
  logic        err0, err2, err3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_BITS(8), .WAIT_STATES(0)) u_dut0 (
    .M_CLK(clk), .Z_R(rst_n), .M_WE(we), .M_ADDR(addr), .M_WR_DATA(wd),
    .M_RD_DATA(rd0), .M_RD_VALID(vld0)
`ifdef DMEM_ERR_EN
    , .M_ERR(err0)
`endif
  );
  dmem_responder #(.DATA_W(32), .ADDR_BITS(8), .WAIT_STATES(2)) u_dut2 (
    .M_CLK(clk), .Z_R(rst_n), .M_WE(we), .M_ADDR(addr), .M_WR_DATA(wd),
    .M_RD_DATA(rd2), .M_RD_VALID(vld2)
`ifdef DMEM_ERR_EN
    , .M_ERR(err2)
`endif
  );
  dmem_responder #(.DATA_W(32), .ADDR_BITS(8), .WAIT_STATES(3)) u_dut3 (
    .M_CLK(clk), .Z_R(rst_n), .M_WE(we), .M_ADDR(addr), .M_WR_DATA(wd),
    .M_RD_DATA(rd3), .M_RD_VALID(vld3)
`ifdef DMEM_ERR_EN
    , .M_ERR(err3)
`endif
  );

`ifndef DMEM_ERR_EN
  assign err0 = 1'b0;
  assign err2 = 1'b0;
  assign err3 = 1'b0;
`endif

  // Per-instance model: memory contents, known flags, and access timing in plain counts.
  logic [31:0] m_ram   [3][256];
  bit          m_known [3][256];
  logic [31:0] m_dat [3];
  bit          m_dk  [3];
  bit          m_vld [3];
  bit          m_err [3];
  int          m_busy[3];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  // Model update: an instance accepts an access only when its previous one has finished.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_dat[k] = '0; m_dk[k] = 1'b1; m_vld[k] = 1'b0; m_err[k] = 1'b0; m_busy[k] = 0;
      end else if (m_busy[k] > 0) begin
        m_busy[k] = m_busy[k] - 1;
        if (m_busy[k] == 0) m_vld[k] = 1'b1;
      end else begin
        m_err[k] = ERR_BUILD && (addr[31:8] != 24'd0);
        if (m_err[k]) begin
          m_dat[k] = '0; m_dk[k] = 1'b1;
        end else if (we) begin
          m_ram[k][addr[7:0]] = wd; m_known[k][addr[7:0]] = 1'b1;
          m_dat[k] = wd; m_dk[k] = 1'b1;
        end else begin
          m_dat[k] = m_ram[k][addr[7:0]]; m_dk[k] = m_known[k][addr[7:0]];
        end
        m_busy[k] = ws_of(k);
        m_vld[k]  = (ws_of(k) == 0);
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    logic [31:0] a_rd;
    logic        a_vld, a_err;
    for (int k = 0; k < 3; k++) begin
      a_rd  = (k == 0) ? rd0  : (k == 1) ? rd2  : rd3;
      a_vld = (k == 0) ? vld0 : (k == 1) ? vld2 : vld3;
      a_err = (k == 0) ? err0 : (k == 1) ? err2 : err3;
      checks = checks + 1;
      if (a_vld !== m_vld[k] || a_err !== m_err[k] || (m_dk[k] && a_rd !== m_dat[k])) begin
        failures = failures + 1;
        $display("FAIL model_cmp inst=%0d t=%0t got rd=%h vld=%b err=%b want rd=%h vld=%b err=%b",
                 k, $time, a_rd, a_vld, a_err, m_dat[k], m_vld[k], m_err[k]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; addr = a; wd = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pre_a [5] = '{32'h2, 32'h3F, 32'h0, 32'h5, 32'h7F};
  logic [31:0] pre_d [5] = '{32'h202, 32'h3F, 32'hA0, 32'h5, 32'h7F7F};

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd0", rd0, 32'h0);
    chk("reset_vld0", {31'd0, vld0}, 32'h0);
    chk("reset_rd3", rd3, 32'h0);
    chk("reset_vld3", {31'd0, vld3}, 32'h0);
    rst_n = 1'b1;

    // Preload, each op held 4 edges so every instance samples it at least once.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, pre_a[i], pre_d[i]);
      repeat (4) step();
    end

    // Reset mid-WAIT on the WAIT_STATES=3 instance (it samples at this edge).
    drive(1'b1, 32'h6, 32'h66);
    step();
    chk("t1_wait_rd3", rd3, 32'h66);
    chk("t1_wait_vld3", {31'd0, vld3}, 32'h0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_rd3", rd3, 32'h0);
    chk("t1_rst_vld3", {31'd0, vld3}, 32'h0);
    chk("t1_rst_rd0", rd0, 32'h0);
    chk("t1_rst_vld0", {31'd0, vld0}, 32'h0);
    drive(1'b0, 32'h2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t1_first_rd3", rd3, 32'h202);
    chk("t1_first_vld3", {31'd0, vld3}, 32'h0);
    chk("t1_first_rd0", rd0, 32'h202);
    chk("t1_first_vld0", {31'd0, vld0}, 32'h1);
    repeat (2) step();
    chk("t1_n2_vld3", {31'd0, vld3}, 32'h0);
    step();
    chk("t1_n3_vld3", {31'd0, vld3}, 32'h1);
    chk("t1_n3_rd3", rd3, 32'h202);

    // Write then read, zero wait states.
    drive(1'b1, 32'h1, 32'h101);
    step();
    chk("t2_wr_rd0", rd0, 32'h101);
    chk("t2_wr_vld0", {31'd0, vld0}, 32'h1);
    drive(1'b0, 32'h1, 32'h0);
    step();
    chk("t2_rd1", rd0, 32'h101);
    drive(1'b0, 32'h2, 32'h0);
    step();
    chk("t2_rd2", rd0, 32'h202);

    // Two wait states: realign with a short reset, then ignored inputs during WAIT.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b0, 32'h3F, 32'h0);
    step();
    chk("t3_n0_rd2", rd2, 32'h3F);
    chk("t3_n0_vld2", {31'd0, vld2}, 32'h0);
    drive(1'b1, 32'h3F, 32'h99);
    step();
    chk("t3_n1_vld2", {31'd0, vld2}, 32'h0);
    chk("t3_n1_rd2", rd2, 32'h3F);
    drive(1'b0, 32'h2, 32'h0);
    step();
    chk("t3_n2_vld2", {31'd0, vld2}, 32'h1);
    chk("t3_n2_rd2", rd2, 32'h3F);
    drive(1'b0, 32'h3F, 32'h0);
    step();
    chk("t3_n3_rd2", rd2, 32'h3F);
    chk("t3_n3_vld2", {31'd0, vld2}, 32'h0);
    chk("t3_n3_rd0", rd0, 32'h99);

    // Upper address bits: wrap in the default build, error in the ERR build.
    drive(1'b1, 32'h17F, 32'hACACACAC);
    step();
    chk("t4_wr_rd0", rd0, ERR_BUILD ? 32'h0 : 32'hACACACAC);
    chk("t4_wr_err0", {31'd0, err0}, ERR_BUILD ? 32'h1 : 32'h0);
    drive(1'b0, 32'h7F, 32'h0);
    step();
    chk("t4_rd7f", rd0, ERR_BUILD ? 32'h7F7F : 32'hACACACAC);
    chk("t4_rd_err0", {31'd0, err0}, 32'h0);

    drive(1'b1, 32'h100, 32'h55);
    step();
    chk("t5_wr_rd0", rd0, ERR_BUILD ? 32'h0 : 32'h55);
    chk("t5_wr_err0", {31'd0, err0}, ERR_BUILD ? 32'h1 : 32'h0);
    chk("t5_wr_vld0", {31'd0, vld0}, 32'h1);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("t5_rd0", rd0, ERR_BUILD ? 32'hA0 : 32'h55);
    chk("t5_rd_err0", {31'd0, err0}, 32'h0);

    // Streamed writes then reads of one-hot addresses.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'd1 << i, 32'h100 + (32'd1 << i));
      step();
      chk("t6_wr", rd0, 32'h100 + (32'd1 << i));
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'd1 << i, 32'h0);
      step();
      chk("t6_rd", rd0, 32'h100 + (32'd1 << i));
      chk("t6_vld", {31'd0, vld0}, 32'h1);
    end

    repeat (6) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
